dmem_responder: RTL and testbench

Memory-side responder for the processor's data-memory port, replacing the combinational data memory with a multi-cycle, handshaked slave. It accepts one load/store request at a time, applies the RISC-V byte/half/word access control (DMCtrl/funct3 encoding), and returns read data with sign or zero extension after a configurable wait. The block sits between the core's load/store path and a word-organised storage array, and flags misaligned, out-of-range or illegal-control accesses.

---
 rtl/dmem_pkg.sv | 42 ++++
 rtl/dmem_lane.sv | 66 ++++++
 rtl/dmem_responder.sv | 201 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder:
//   - req_ctrl access-size encodings (RISC-V funct3 style)
//   - responder FSM state type
//   - ctrl_fault(): illegal-control / misalignment check for one request
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam logic [2:0] CTRL_B  = 3'b000;
    localparam logic [2:0] CTRL_H  = 3'b001;
    localparam logic [2:0] CTRL_W  = 3'b010;
    localparam logic [2:0] CTRL_BU = 3'b100;
    localparam logic [2:0] CTRL_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Returns 1 when the control code is illegal, when an unsigned code is
    // used for a store, or when the address is misaligned for the size.
    function automatic logic ctrl_fault(
        input logic [2:0] ctrl,
        input logic [1:0] addr_lo,
        input logic       we
    );
        logic f;
        f = 1'b0;
        case (ctrl)
            CTRL_B:  f = 1'b0;
            CTRL_H:  f = addr_lo[0];
            CTRL_W:  f = (addr_lo != 2'b00);
            CTRL_BU: f = we;
            CTRL_HU: f = we | addr_lo[0];
            default: f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// -----------------------------------------------------------------------------
// dmem_lane
// Combinational byte-lane datapath for one access.
//   i_ctrl     : access size / signedness code
//   i_addr_lo  : byte offset within the word
//   i_wdata    : right-aligned store data
//   i_rword    : current contents of the addressed word
//   o_rdata    : load result, shifted and extended
//   o_wword    : word with the store lanes merged in
//   o_be       : byte enables of the store
// -----------------------------------------------------------------------------
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [2:0]  i_ctrl,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [31:0] o_rdata,
    output logic [31:0] o_wword,
    output logic [3:0]  o_be
);

    logic [31:0] w_shift;
    logic [31:0] w_wlanes;

    // Load path: bring the addressed byte/half down to bit 0, then extend.
    always_comb begin
        w_shift = i_rword >> {i_addr_lo, 3'b000};
        case (i_ctrl)
            CTRL_B:  o_rdata = {{24{w_shift[7]}}, w_shift[7:0]};
            CTRL_H:  o_rdata = {{16{w_shift[15]}}, w_shift[15:0]};
            CTRL_W:  o_rdata = w_shift;
            CTRL_BU: o_rdata = {24'h000000, w_shift[7:0]};
            CTRL_HU: o_rdata = {16'h0000, w_shift[15:0]};
            default: o_rdata = 32'h0000_0000;
        endcase
    end

    // Store path: replicate the data across lanes so every enabled lane
    // already holds the right byte, then merge under the byte enables.
    always_comb begin
        case (i_ctrl)
            CTRL_B: begin
                w_wlanes = {4{i_wdata[7:0]}};
                o_be     = 4'b0001 << i_addr_lo;
            end
            CTRL_H: begin
                w_wlanes = {2{i_wdata[15:0]}};
                o_be     = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            CTRL_W: begin
                w_wlanes = i_wdata;
                o_be     = 4'b1111;
            end
            default: begin
                w_wlanes = 32'h0000_0000;
                o_be     = 4'b0000;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            o_wword[i*8 +: 8] = o_be[i] ? w_wlanes[i*8 +: 8] : i_rword[i*8 +: 8];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Multi-cycle handshaked data-memory slave with byte/half/word access control.
//   clk, rst_n              : clock, asynchronous active-low reset
//   req_valid/req_ready     : request handshake (ready only in IDLE)
//   req_we, req_addr,
//   req_wdata, req_ctrl     : request payload
//   rsp_valid/rsp_ready     : response handshake
//   rsp_rdata, rsp_err      : load data (0 for stores/errors), error flag
// Parameters: DEPTH_WORDS (words of storage), LATENCY (wait cycles, 0..15).
// -----------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_ctrl,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
    localparam logic [3:0]  LAT_M1    = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_ctrl;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic        w_accept;
    logic        w_q_we;
    logic [31:0] w_q_addr;
    logic [31:0] w_q_wdata;
    logic [2:0]  w_q_ctrl;
    logic        w_err;
    logic        w_commit;
    logic [31:0] w_rword;
    logic [31:0] w_lane_rdata;
    logic [31:0] w_lane_wword;
    logic [3:0]  w_lane_be;
    logic        w_req_ready_nxt;
    logic        w_rsp_valid_nxt;
    logic [31:0] w_rsp_rdata_nxt;
    logic        w_rsp_err_nxt;

    assign w_accept = (r_state == ST_IDLE) && req_valid;

    // With LATENCY=0 the commit happens on the accepting edge, so the live
    // request inputs are used in IDLE; otherwise the latched copy is used.
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_q_we    = req_we;
            w_q_addr  = req_addr;
            w_q_wdata = req_wdata;
            w_q_ctrl  = req_ctrl;
        end else begin
            w_q_we    = r_we;
            w_q_addr  = r_addr;
            w_q_wdata = r_wdata;
            w_q_ctrl  = r_ctrl;
        end
    end

    assign w_err   = ctrl_fault(w_q_ctrl, w_q_addr[1:0], w_q_we) ||
                     (w_q_addr[31:2] >= DEPTH_LIM);
    assign w_rword = r_mem[w_q_addr[AW+1:2]];

    // Commit only on the edge that enters RESP; gating with rst_n keeps a
    // store from landing while the FSM is held in reset.
    assign w_commit = rst_n && (w_next == ST_RESP) && (r_state != ST_RESP);

    dmem_lane u_lane (
        .i_ctrl    (w_q_ctrl),
        .i_addr_lo (w_q_addr[1:0]),
        .i_wdata   (w_q_wdata),
        .i_rword   (w_rword),
        .o_rdata   (w_lane_rdata),
        .o_wword   (w_lane_wword),
        .o_be      (w_lane_be)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_next = (LATENCY == 0) ? ST_RESP : ST_WAIT;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = ST_RESP;
                end else begin
                    w_next = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_RESP;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered handshake/response outputs.
    always_comb begin
        w_req_ready_nxt = (w_next == ST_IDLE);
        w_rsp_valid_nxt = (w_next == ST_RESP);
        w_rsp_rdata_nxt = 32'h0000_0000;
        w_rsp_err_nxt   = 1'b0;
        if (w_commit) begin
            w_rsp_err_nxt   = w_err;
            w_rsp_rdata_nxt = (w_err || w_q_we) ? 32'h0000_0000 : w_lane_rdata;
        end else if (w_next == ST_RESP) begin
            w_rsp_err_nxt   = r_rsp_err;
            w_rsp_rdata_nxt = r_rsp_rdata;
        end else begin
            w_rsp_err_nxt   = 1'b0;
            w_rsp_rdata_nxt = 32'h0000_0000;
        end
    end

    // Registered outputs, wait counter and request latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0000_0000;
            r_rsp_err   <= 1'b0;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_addr      <= 32'h0000_0000;
            r_wdata     <= 32'h0000_0000;
            r_ctrl      <= 3'b000;
        end else begin
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_ctrl  <= req_ctrl;
                r_cnt   <= LAT_M1;
            end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    // Storage array (not reset); written once per store at the commit edge.
    always_ff @(posedge clk) begin
        if (w_commit && w_q_we && !w_err) begin
            r_mem[w_q_addr[AW+1:2]] <= w_lane_wword;
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 1;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_ctrl;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int total;
    int bad;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ctrl  (req_ctrl),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // One full transaction. Reports response data/err and the number of
    // clock edges from the accepting edge (inclusive) to rsp_valid.
    task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] ctrl, input int stall,
                        output logic [31:0] rdata, output logic err, output int lat);
        int n;
        lat   = 0;
        rdata = 32'h0;
        err   = 1'b0;
        n     = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_ctrl  = ctrl;
        req_valid = 1'b1;
        rsp_ready = (stall == 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_wdata = 32'hA5A5_A5A5;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("rsp_valid_wait", {31'd0, rsp_valid}, 32'd1);
        rdata = rsp_rdata;
        err   = rsp_err;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
            chk("stall_ready", {31'd0, req_ready}, 32'd0);
            chk("stall_rdata", rsp_rdata, rdata);
            chk("stall_err", {31'd0, rsp_err}, {31'd0, err});
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("rsp_drop", {31'd0, rsp_valid}, 32'd0);
        chk("req_ready_back", {31'd0, req_ready}, 32'd1);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lt;

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_ctrl  = 3'b000;
        rsp_ready = 1'b1;
        #12;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // word store and load
        xfer(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 0, rd, er, lt);
        chk("sw_lat", lt, 32'd2);
        chk("sw_rdata", rd, 32'h0);
        chk("sw_err", {31'd0, er}, 32'd0);
        xfer(1'b0, 32'h10, 32'h0, 3'b010, 0, rd, er, lt);
        chk("lw_lat", lt, 32'd2);
        chk("lw_rdata", rd, 32'hDEADBEEF);
        chk("lw_err", {31'd0, er}, 32'd0);

        // sub-word loads with extension
        xfer(1'b0, 32'h13, 32'h0, 3'b000, 0, rd, er, lt);
        chk("lb_13", rd, 32'hFFFFFFDE);
        xfer(1'b0, 32'h13, 32'h0, 3'b100, 0, rd, er, lt);
        chk("lbu_13", rd, 32'h000000DE);
        xfer(1'b0, 32'h12, 32'h0, 3'b001, 0, rd, er, lt);
        chk("lh_12", rd, 32'hFFFFDEAD);
        xfer(1'b0, 32'h10, 32'h0, 3'b101, 0, rd, er, lt);
        chk("lhu_10", rd, 32'h0000BEEF);
        xfer(1'b0, 32'h10, 32'h0, 3'b000, 0, rd, er, lt);
        chk("lb_10", rd, 32'hFFFFFFEF);

        // byte store merges into one lane
        xfer(1'b1, 32'h11, 32'hFFFFFF55, 3'b000, 0, rd, er, lt);
        chk("sb_err", {31'd0, er}, 32'd0);
        xfer(1'b0, 32'h10, 32'h0, 3'b010, 0, rd, er, lt);
        chk("lw_after_sb", rd, 32'hDEAD55EF);

        // half store to upper half of another word
        xfer(1'b1, 32'h22, 32'h0000_1234, 3'b001, 0, rd, er, lt);
        xfer(1'b1, 32'h20, 32'h0000_ABCD, 3'b001, 0, rd, er, lt);
        xfer(1'b0, 32'h20, 32'h0, 3'b010, 0, rd, er, lt);
        chk("lw_after_sh", rd, 32'h1234ABCD);

        // error cases
        xfer(1'b0, 32'h12, 32'h0, 3'b010, 0, rd, er, lt);
        chk("lw_mis_err", {31'd0, er}, 32'd1);
        chk("lw_mis_rdata", rd, 32'h0);
        xfer(1'b0, 32'h11, 32'h0, 3'b001, 0, rd, er, lt);
        chk("lh_mis_err", {31'd0, er}, 32'd1);
        xfer(1'b1, 32'h10, 32'h0000_0000, 3'b011, 0, rd, er, lt);
        chk("ctrl011_err", {31'd0, er}, 32'd1);
        chk("ctrl011_rdata", rd, 32'h0);
        xfer(1'b1, 32'h10, 32'h0000_0000, 3'b100, 0, rd, er, lt);
        chk("sbu_err", {31'd0, er}, 32'd1);
        xfer(1'b0, 32'h10, 32'h0, 3'b010, 0, rd, er, lt);
        chk("lw_unchanged", rd, 32'hDEAD55EF);
        chk("lw_unchanged_err", {31'd0, er}, 32'd0);

        // out-of-range store with a stalled response
        xfer(1'b1, DEPTH * 4, 32'h0000_0000, 3'b010, 5, rd, er, lt);
        chk("range_err", {31'd0, er}, 32'd1);
        xfer(1'b0, (DEPTH - 1) * 4 + 32'h0, 32'h0, 3'b010, 0, rd, er, lt);
        chk("last_word_err", {31'd0, er}, 32'd0);
        // word 0 aliases the out-of-range index; it must not have been written
        xfer(1'b1, 32'h0, 32'h0BAD_F00D, 3'b010, 0, rd, er, lt);
        xfer(1'b1, DEPTH * 4, 32'h0000_0000, 3'b010, 0, rd, er, lt);
        xfer(1'b0, 32'h0, 32'h0, 3'b010, 0, rd, er, lt);
        chk("alias_unchanged", rd, 32'h0BADF00D);

        // reset during WAIT discards the store
        req_we    = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 32'h1234_5678;
        req_ctrl  = 3'b010;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("wait_no_valid", {31'd0, rsp_valid}, 32'd0);
        rst_n = 1'b0;
        #2;
        chk("rstw_req_ready", {31'd0, req_ready}, 32'd1);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rstw_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        xfer(1'b0, 32'h10, 32'h0, 3'b010, 0, rd, er, lt);
        chk("rstw_old_value", rd, 32'hDEAD55EF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
